// File: rtl/arbitro_rr.sv
// Round-robin arbiter with bounded grant tenure: an owner keeps gnt while requesting,
// up to MAX_HOLD cycles, then the grant rotates to the next pending requester without a gap.
module arbitro_rr #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]      state_reg, state_next;
    logic [ID_W-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [N-1:0]    gnt_reg, gnt_next;
    logic [ID_W-1:0] gnt_id_reg, gnt_id_next;
    logic            busy_reg, busy_next;

    logic            active_next;
    logic            mask_en;
    logic [ID_W-1:0] owner_inc;
    logic [ID_W-1:0] search_base;
    logic            owner_req;
    logic            release_now;

    logic [N-1:0]    cand;
    logic [2*N-1:0]  cand_dbl;
    logic [N-1:0]    rot;
    logic [N:0]      seen;
    logic [N-1:0]    first;
    logic [ID_W-1:0] idx_or [N+1];
    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic [N-1:0]    gnt_dec;

    assign owner_inc   = (gnt_id_reg == ID_W'(N - 1)) ? '0 : gnt_id_reg + ID_W'(1);
    assign owner_req   = |(req & gnt_reg);
    assign release_now = !owner_req || (cnt_reg == CNT_LAST);
    assign mask_en     = (state_reg == ST_GRANT);
    // While granting, the search always starts just past the owner and skips the owner itself.
    assign search_base = mask_en ? owner_inc : ptr_reg;

    // Rotate candidates so position 0 is the search start, then pick the lowest set bit.
    assign cand_dbl = {cand, cand} >> search_base;
    assign rot      = cand_dbl[N-1:0];
    assign seen[0]  = 1'b0;
    assign idx_or[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_search
            logic [ID_W:0] sum;
            logic [ID_W:0] wrapped;

            assign cand[gi]  = req[gi] & ~(mask_en & (gnt_id_reg == ID_W'(gi)));
            assign seen[gi+1] = seen[gi] | rot[gi];
            assign first[gi] = rot[gi] & ~seen[gi];
            assign sum       = {1'b0, search_base} + (ID_W+1)'(gi);
            assign wrapped   = (sum >= (ID_W+1)'(N)) ? sum - (ID_W+1)'(N) : sum;
            assign idx_or[gi+1] = idx_or[gi] | (first[gi] ? wrapped[ID_W-1:0] : '0);
            assign gnt_dec[gi] = (gnt_id_next == ID_W'(gi));
        end
    endgenerate

    assign win_found = seen[N];
    assign win_idx   = idx_or[N];

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        gnt_id_next = gnt_id_reg;
        active_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next  = ST_GRANT;
                    gnt_id_next = win_idx;
                    cnt_next    = '0;
                    active_next = 1'b1;
                end
            end
            default: begin
                if (!release_now) begin
                    cnt_next    = cnt_reg + CNT_W'(1);
                    active_next = 1'b1;
                end else begin
                    ptr_next = owner_inc;
                    if (win_found) begin
                        gnt_id_next = win_idx;
                        cnt_next    = '0;
                        active_next = 1'b1;
                    end else if (owner_req) begin
                        // Timed out with nobody else waiting: restart tenure without dropping gnt.
                        cnt_next    = '0;
                        active_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase

        gnt_next  = active_next ? gnt_dec : '0;
        busy_next = active_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            busy_reg   <= busy_next;
        end
    end

    assign gnt    = gnt_reg;
    assign gnt_id = gnt_id_reg;
    assign busy   = busy_reg;

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
N-requester round-robin arbiter with a bounded grant tenure, for sharing one resource among several requesters.
- A requester holds its grant while it keeps its request high, up to MAX_HOLD cycles.
- On release or timeout, the grant rotates to the next pending requester, with no idle gap.
- Sits between the requesting agents and the shared resource; the registered, one-hot gnt drives the resource-side select.

Parameters:
N, 4, number of requesters (2..16)
MAX_HOLD, 8, maximum consecutive cycles one grant may last (>=1)
ID_W, 2, width of gnt_id; must equal clog2(N)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  N  request vector, bit i = requester i; level-sensitive
gnt  output  N  grant vector, registered, one-hot or all-zero
gnt_id  output  ID_W  index of current owner (last owner when idle)
busy  output  1  high while any grant is asserted

Behaviour:
- Reset (sync, active-high, sampled on the clock edge):
  - gnt=0, gnt_id=0, busy=0, state=IDLE.
  - Priority pointer ptr=0, so requester 0 has first priority.
  - Hold counter cnt=0.
  - Reset overrides all other activity. Asserted mid-grant, gnt drops on that same edge.
- State machine: IDLE, GRANT.
- Round-robin search: the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N.
- IDLE:
  - Any req bit set at an edge: on that edge gnt[w]=1 for the search winner w.
  - Same edge: gnt_id=w, cnt=0, busy=1, go to GRANT.
  - Latency is 1 cycle from req sampled high to gnt high.
  - No request: remain in IDLE; gnt_id holds its value.
- GRANT, owner o, evaluated at each edge:
  - req[o]=1 and cnt<MAX_HOLD-1: keep the grant, cnt++.
  - Release: req[o]=0 at the edge, or req[o]=1 and cnt==MAX_HOLD-1 (timeout).
    - Set ptr=(o+1) mod N, then search using the current req with bit o masked off.
    - Winner w found: gnt switches directly to w on this edge, gnt_id=w, cnt=0.
    - No winner, but the timed-out owner still requests: re-grant o, cnt=0; gnt stays high continuously.
    - Otherwise: gnt=0, busy=0, go to IDLE.
- A continuously requesting owner with other requesters pending holds gnt for exactly MAX_HOLD cycles.
- MAX_HOLD=1 rotates every cycle among active requesters.
- gnt is never multi-hot. A new grant is never issued to a requester whose req is low at the deciding edge.
- A request that drops before being granted is simply lost; there is no latching.
- Simultaneous requests are resolved purely by ptr. No requester starves: wait <= (N-1)*MAX_HOLD cycles after req rises.
- All outputs come directly from flops; there are no combinational paths from req to gnt.
- cnt width: clog2(MAX_HOLD), minimum 1. ptr/gnt_id arithmetic wraps modulo N.

Test Plan:
All scenarios use N=4, MAX_HOLD=4, clock period 10, reset high for 2 edges then low.

1. Reset check: during and after reset with req=0 -> gnt=0000, gnt_id=0, busy=0; reset asserted mid-grant -> gnt=0000 on that edge.
2. Single request: req=0001 for 3 cycles then 0000 -> gnt=0001 from the edge after req rises, held 3 cycles, drops on the first edge sampling req[0]=0; busy mirrors |gnt.
3. Simultaneous requests: req=1111 held, from ptr=0 -> grant order 0,1,2,3,0..., each gnt bit high exactly 4 cycles, no gap between grants, gnt always one-hot, gnt_id steps 0,1,2,3,0.
4. Fairness after release: req0 granted and releases at cycle 2 while req=1010 -> next gnt=0010 (requester 1), then 1000 (requester 3); requester 0 re-requesting is served only after 3.
5. Lone timeout: only req=0100 held 10 cycles -> gnt=0100 continuous for 10 cycles (re-grant at timeout with no deassertion), cnt restarts every 4 cycles.
6. Request glitch: req[2] high for 1 cycle while requester 1 owns the grant -> requester 2 never granted; after owner releases with req=0000 -> gnt=0000, busy=0, gnt_id stays 1.
